axi_rw_sched: RTL and testbench
===============================

// Module: axi_rw_sched
// PURPOSE
//  Slave-side AXI request scheduler for the AXI-to-APB bridge. Accepts single-beat
//  AXI writes (AW+W) and reads (AR), arbitrates round-robin, and issues one command
//  at a time to the single backend (APB master) port. It returns the result on B or R.
//  Only one transaction is outstanding at any time; bursts are rejected with SLVERR.
// PARAMETERS
//  C_AXI_ID_WIDTH    5    AWID/ARID/BID/RID width
//  C_AXI_ADDR_WIDTH  32   address width
//  C_AXI_DATA_WIDTH  64   data width
//  C_AXI_STRB_WIDTH  8    write strobe width (DATA/8)
//  C_AXI_LEN_WIDTH   4    AWLEN/ARLEN width
//  RSP_TIMEOUT       256  max cycles in WAIT before DECERR; 0 = no timeout
// PORTS
//  AXI_ACLK     in  1     clock
//  AXI_ARESET   in  1     synchronous reset, active-high
//  AXI_AWID/AWADDR/AWLEN in ID/ADDR/LEN  write address; AXI_AWVALID in 1; AXI_AWREADY out 1
//  AXI_WDATA/WSTRB in DATA/STRB  write data; AXI_WLAST in 1; AXI_WVALID in 1; AXI_WREADY out 1
//  AXI_BID out ID; AXI_BRESP out 2; AXI_BVALID out 1; AXI_BREADY in 1
//  AXI_ARID/ARADDR/ARLEN in ID/ADDR/LEN  read address; AXI_ARVALID in 1; AXI_ARREADY out 1
//  AXI_RID out ID; AXI_RDATA out DATA; AXI_RRESP out 2; AXI_RLAST out 1; AXI_RVALID out 1; AXI_RREADY in 1
//  CMD_VALID out 1; CMD_READY in 1; CMD_WRITE out 1; CMD_ADDR out ADDR
//  CMD_WDATA out DATA; CMD_WSTRB out STRB  backend command
//  RSP_VALID in 1; RSP_RDATA in DATA; RSP_ERR in 1   backend completion (1-cycle pulse)
// BEHAVIOUR
//  Reset: state=IDLE; all VALID/READY outputs 0; BID/RID/BRESP/RRESP/RDATA/CMD_* 0;
//   last_grant=READ, so the first contended grant goes to write. A reset mid-transaction drops it silently.
//  FSM IDLE -> CMD -> WAIT -> RESP -> IDLE (the ERR path goes IDLE -> RESP).
//  IDLE: wr_req = AWVALID & WVALID; rd_req = ARVALID.
//   Both requests present: grant the opposite of last_grant. Otherwise grant the single requester.
//   Write grant: AWREADY=WREADY=1 this cycle only (combinational, IDLE only); ARREADY=0.
//   Read grant: ARREADY=1 this cycle only; AWREADY=WREADY=0.
//   AW without W, or W without AW: neither accepted; wait.
//   Latch ID/ADDR/DATA/STRB/dir on grant; last_grant <= granted dir.
//   Illegal: AWLEN!=0, WLAST=0, or ARLEN!=0 -> skip backend, go RESP with resp=2'b10, RDATA=0.
//   Otherwise -> CMD.
//  CMD: CMD_VALID=1 and CMD_* stable until CMD_READY=1, then -> WAIT. No timeout in CMD.
//  WAIT: cnt increments each cycle.
//   RSP_VALID=1 -> capture RSP_RDATA (reads only); resp = RSP_ERR ? 2'b10 : 2'b00; -> RESP.
//   RSP_TIMEOUT!=0 and cnt==RSP_TIMEOUT-1 without RSP_VALID -> resp=2'b11, RDATA=0, -> RESP.
//   RSP_VALID in any state other than WAIT is ignored (late or early responses are dropped).
//  RESP: write -> BVALID=1, BID=latched ID, BRESP=resp.
//   Read -> RVALID=1, RID, RDATA, RRESP=resp, RLAST=1.
//   Hold stable until BREADY/RREADY. The cycle after the handshake: VALID=0, state IDLE,
//   and the next grant is possible in that same IDLE cycle.
//  Latency, ideal (CMD_READY=1, RSP_VALID same cycle as WAIT entry):
//   accept @t, CMD_VALID @t+1, WAIT @t+2, B/RVALID @t+3.
//  cnt: $clog2(RSP_TIMEOUT+1) bits; cleared on WAIT entry. No wrap: the timeout fires first.
//  All outputs are registered except the AWREADY/WREADY/ARREADY grant strobes.
// TESTING
//  1 Write AWADDR=0x100, WDATA=0x1122334455667788, WSTRB=0xFF, ID=3; CMD_READY=1; RSP ok at once
//    -> CMD_WRITE=1, CMD_ADDR=0x100 @t+1; BVALID, BID=3, BRESP=00 @t+3.
//  2 Read ARADDR=0x200, ID=7; backend returns RSP_RDATA=0xDEAD_BEEF after 5 WAIT cycles
//    -> RVALID, RID=7, RDATA=0xDEADBEEF, RRESP=00, RLAST=1.
//  3 AW+W and AR asserted together for 4 back-to-back transactions after reset
//    -> grant order W, R, W, R; never two READY strobes in one cycle.
//  4 AWLEN=1 (burst) -> CMD_VALID never asserted, BRESP=10. ARLEN=3 -> RRESP=10, RDATA=0.
//  5 RSP_TIMEOUT=8, read, backend silent -> RRESP=11 exactly 8 cycles after WAIT entry;
//    an RSP_VALID arriving later is ignored.
//  6 Reset asserted during WAIT and during RESP with BREADY=0
//    -> next cycle all VALID=0, state IDLE; a new write completes normally.

Source files
------------

// File: rtl/axi_rw_sched.sv
`default_nettype none
// ============================================================================
//  Module      : axi_rw_sched
//  Description : Slave-side AXI request scheduler for the AXI-to-APB bridge.
//                Accepts single-beat writes (AW+W) and reads (AR) and
//                arbitrates between them round-robin. It issues one command
//                at a time to the backend and returns the result on B or R.
//                Bursts are answered with SLVERR without touching the
//                backend. A silent backend is answered with DECERR after
//                RSP_TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_rw_sched #(
    parameter int C_AXI_ID_WIDTH   = 5,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int C_AXI_DATA_WIDTH = 64,
    parameter int C_AXI_STRB_WIDTH = 8,
    parameter int C_AXI_LEN_WIDTH  = 4,
    parameter int RSP_TIMEOUT      = 256
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_ARESET,
    // write address
    input  logic [C_AXI_ID_WIDTH-1:0]   AXI_AWID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_AWADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]  AXI_AWLEN,
    input  logic                        AXI_AWVALID,
    output logic                        AXI_AWREADY,
    // write data
    input  logic [C_AXI_DATA_WIDTH-1:0] AXI_WDATA,
    input  logic [C_AXI_STRB_WIDTH-1:0] AXI_WSTRB,
    input  logic                        AXI_WLAST,
    input  logic                        AXI_WVALID,
    output logic                        AXI_WREADY,
    // write response
    output logic [C_AXI_ID_WIDTH-1:0]   AXI_BID,
    output logic [1:0]                  AXI_BRESP,
    output logic                        AXI_BVALID,
    input  logic                        AXI_BREADY,
    // read address
    input  logic [C_AXI_ID_WIDTH-1:0]   AXI_ARID,
    input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
    input  logic [C_AXI_LEN_WIDTH-1:0]  AXI_ARLEN,
    input  logic                        AXI_ARVALID,
    output logic                        AXI_ARREADY,
    // read data
    output logic [C_AXI_ID_WIDTH-1:0]   AXI_RID,
    output logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
    output logic [1:0]                  AXI_RRESP,
    output logic                        AXI_RLAST,
    output logic                        AXI_RVALID,
    input  logic                        AXI_RREADY,
    // backend command
    output logic                        CMD_VALID,
    input  logic                        CMD_READY,
    output logic                        CMD_WRITE,
    output logic [C_AXI_ADDR_WIDTH-1:0] CMD_ADDR,
    output logic [C_AXI_DATA_WIDTH-1:0] CMD_WDATA,
    output logic [C_AXI_STRB_WIDTH-1:0] CMD_WSTRB,
    // backend completion
    input  logic                        RSP_VALID,
    input  logic [C_AXI_DATA_WIDTH-1:0] RSP_RDATA,
    input  logic                        RSP_ERR
);

    // A zero timeout still gets a 1-bit counter so the declarations stay legal.
    localparam int               CNT_W    = (RSP_TIMEOUT > 0) ? $clog2(RSP_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (RSP_TIMEOUT > 0) ? CNT_W'(RSP_TIMEOUT - 1) : '0;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                      state_q,     state_d;
    logic                        last_wr_q,   last_wr_d;   // 0 = last grant was a read
    logic [C_AXI_ID_WIDTH-1:0]   id_q,        id_d;
    logic                        cmd_valid_q, cmd_valid_d;
    logic                        cmd_write_q, cmd_write_d;
    logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr_q,  cmd_addr_d;
    logic [C_AXI_DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [C_AXI_STRB_WIDTH-1:0] cmd_wstrb_q, cmd_wstrb_d;
    logic [CNT_W-1:0]            cnt_q,       cnt_d;
    logic                        bvalid_q,    bvalid_d;
    logic [C_AXI_ID_WIDTH-1:0]   bid_q,       bid_d;
    logic [1:0]                  bresp_q,     bresp_d;
    logic                        rvalid_q,    rvalid_d;
    logic [C_AXI_ID_WIDTH-1:0]   rid_q,       rid_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic [1:0]                  rresp_q,     rresp_d;
    logic                        rlast_q,     rlast_d;

    logic                        w_wr_req;
    logic                        w_rd_req;
    logic                        w_grant_wr;
    logic                        w_grant_rd;
    logic                        w_illegal;
    logic                        w_aw_ready;
    logic                        w_ar_ready;
    logic                        w_resp_load;
    logic [1:0]                  w_resp_code;
    logic [C_AXI_DATA_WIDTH-1:0] w_resp_data;

    // Next-state, arbitration, grant strobes and response loading.
    always_comb begin
        state_d     = state_q;
        last_wr_d   = last_wr_q;
        id_d        = id_q;
        cmd_valid_d = cmd_valid_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_wstrb_d = cmd_wstrb_q;
        cnt_d       = cnt_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        rvalid_d    = rvalid_q;
        rid_d       = rid_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        w_aw_ready  = 1'b0;
        w_ar_ready  = 1'b0;
        w_resp_load = 1'b0;
        w_resp_code = RESP_OKAY;
        w_resp_data = '0;

        // A write needs both AW and W present; on contention the direction
        // that did not win last time gets the grant.
        w_wr_req   = AXI_AWVALID && AXI_WVALID;
        w_rd_req   = AXI_ARVALID;
        w_grant_wr = w_wr_req && (!w_rd_req || !last_wr_q);
        w_grant_rd = w_rd_req && !w_grant_wr;
        w_illegal  = w_grant_wr ? ((AXI_AWLEN != '0) || !AXI_WLAST)
                                : (AXI_ARLEN != '0);

        case (state_q)
            ST_IDLE: begin
                if (w_grant_wr || w_grant_rd) begin
                    w_aw_ready  = w_grant_wr;
                    w_ar_ready  = w_grant_rd;
                    last_wr_d   = w_grant_wr;
                    cmd_write_d = w_grant_wr;
                    id_d        = w_grant_wr ? AXI_AWID   : AXI_ARID;
                    cmd_addr_d  = w_grant_wr ? AXI_AWADDR : AXI_ARADDR;
                    cmd_wdata_d = w_grant_wr ? AXI_WDATA  : '0;
                    cmd_wstrb_d = w_grant_wr ? AXI_WSTRB  : '0;
                    if (w_illegal) begin
                        // bursts never reach the backend
                        w_resp_load = 1'b1;
                        w_resp_code = RESP_SLVERR;
                        state_d     = ST_RESP;
                    end else begin
                        cmd_valid_d = 1'b1;
                        state_d     = ST_CMD;
                    end
                end
            end
            ST_CMD: begin
                if (CMD_READY) begin
                    cmd_valid_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (RSP_VALID) begin
                    w_resp_load = 1'b1;
                    w_resp_code = RSP_ERR ? RESP_SLVERR : RESP_OKAY;
                    w_resp_data = RSP_RDATA;
                    state_d     = ST_RESP;
                end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    w_resp_load = 1'b1;
                    w_resp_code = RESP_DECERR;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if ((bvalid_q && AXI_BREADY) || (rvalid_q && AXI_RREADY)) begin
                    bvalid_d = 1'b0;
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The direction and ID come from the _d side so that the IDLE error
        // path, which grants and responds in the same cycle, sees them.
        if (w_resp_load) begin
            if (cmd_write_d) begin
                bvalid_d = 1'b1;
                bid_d    = id_d;
                bresp_d  = w_resp_code;
            end else begin
                rvalid_d = 1'b1;
                rid_d    = id_d;
                rresp_d  = w_resp_code;
                rdata_d  = w_resp_data;
                rlast_d  = 1'b1;
            end
        end
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state_q     <= ST_IDLE;
            last_wr_q   <= 1'b0;
            id_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_wstrb_q <= '0;
            cnt_q       <= '0;
            bvalid_q    <= 1'b0;
            bid_q       <= '0;
            bresp_q     <= 2'b00;
            rvalid_q    <= 1'b0;
            rid_q       <= '0;
            rdata_q     <= '0;
            rresp_q     <= 2'b00;
            rlast_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_wr_q   <= last_wr_d;
            id_q        <= id_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_wstrb_q <= cmd_wstrb_d;
            cnt_q       <= cnt_d;
            bvalid_q    <= bvalid_d;
            bid_q       <= bid_d;
            bresp_q     <= bresp_d;
            rvalid_q    <= rvalid_d;
            rid_q       <= rid_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
        end
    end

    assign AXI_AWREADY = w_aw_ready;
    assign AXI_WREADY  = w_aw_ready;
    assign AXI_ARREADY = w_ar_ready;
    assign AXI_BID     = bid_q;
    assign AXI_BRESP   = bresp_q;
    assign AXI_BVALID  = bvalid_q;
    assign AXI_RID     = rid_q;
    assign AXI_RDATA   = rdata_q;
    assign AXI_RRESP   = rresp_q;
    assign AXI_RLAST   = rlast_q;
    assign AXI_RVALID  = rvalid_q;
    assign CMD_VALID   = cmd_valid_q;
    assign CMD_WRITE   = cmd_write_q;
    assign CMD_ADDR    = cmd_addr_q;
    assign CMD_WDATA   = cmd_wdata_q;
    assign CMD_WSTRB   = cmd_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_rw_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_rw_sched
//  Description : Directed self-checking bench for axi_rw_sched. It applies a
//                table of single transactions, then runs hand-written
//                sequences for arbitration and reset in mid-transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_rw_sched;

    localparam int IDW = 5;
    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int SW  = 8;
    localparam int LW  = 4;
    localparam int TMO = 8;
    localparam logic [DW-1:0] JUNK = 64'hBADB_ADBA_DBAD_BADB;

    logic           clk = 1'b0;
    logic           rst;
    logic [IDW-1:0] awid, arid, bid, rid;
    logic [AW-1:0]  awaddr, araddr, cmd_addr;
    logic [LW-1:0]  awlen, arlen;
    logic           awvalid, awready, wvalid, wready, wlast;
    logic [DW-1:0]  wdata, rdata, cmd_wdata, rsp_rdata;
    logic [SW-1:0]  wstrb, cmd_wstrb;
    logic [1:0]     bresp, rresp;
    logic           bvalid, bready, arvalid, arready, rvalid, rready, rlast;
    logic           cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_err;

    always #5 clk = ~clk;

    axi_rw_sched #(
        .C_AXI_ID_WIDTH  (IDW),
        .C_AXI_ADDR_WIDTH(AW),
        .C_AXI_DATA_WIDTH(DW),
        .C_AXI_STRB_WIDTH(SW),
        .C_AXI_LEN_WIDTH (LW),
        .RSP_TIMEOUT     (TMO)
    ) dut (
        .AXI_ACLK   (clk),
        .AXI_ARESET (rst),
        .AXI_AWID   (awid),
        .AXI_AWADDR (awaddr),
        .AXI_AWLEN  (awlen),
        .AXI_AWVALID(awvalid),
        .AXI_AWREADY(awready),
        .AXI_WDATA  (wdata),
        .AXI_WSTRB  (wstrb),
        .AXI_WLAST  (wlast),
        .AXI_WVALID (wvalid),
        .AXI_WREADY (wready),
        .AXI_BID    (bid),
        .AXI_BRESP  (bresp),
        .AXI_BVALID (bvalid),
        .AXI_BREADY (bready),
        .AXI_ARID   (arid),
        .AXI_ARADDR (araddr),
        .AXI_ARLEN  (arlen),
        .AXI_ARVALID(arvalid),
        .AXI_ARREADY(arready),
        .AXI_RID    (rid),
        .AXI_RDATA  (rdata),
        .AXI_RRESP  (rresp),
        .AXI_RLAST  (rlast),
        .AXI_RVALID (rvalid),
        .AXI_RREADY (rready),
        .CMD_VALID  (cmd_valid),
        .CMD_READY  (cmd_ready),
        .CMD_WRITE  (cmd_write),
        .CMD_ADDR   (cmd_addr),
        .CMD_WDATA  (cmd_wdata),
        .CMD_WSTRB  (cmd_wstrb),
        .RSP_VALID  (rsp_valid),
        .RSP_RDATA  (rsp_rdata),
        .RSP_ERR    (rsp_err)
    );

    // One single-beat transaction and what must come back.
    // delay = WAIT cycles before the backend answers, -1 = backend silent.
    // stall = CMD cycles with CMD_READY low; bstall = RESP cycles with READY low.
    typedef struct {
        bit             wr;
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  data;    // WDATA for writes, RSP_RDATA for reads
        logic [SW-1:0]  strb;
        logic [LW-1:0]  len;
        bit             wlast;
        int             stall;
        int             delay;
        bit             err;
        int             bstall;
        bit             legal;
        logic [1:0]     resp;
        logic [DW-1:0]  rdata;
        int             lat;     // cycles from accept to B/RVALID
    } vec_t;

    vec_t vecs [10];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_valids"}, {awready, wready, arready, bvalid, rvalid, rlast, cmd_valid}, 0);
        chk({nm, "_ids_resps"}, {bid, rid, bresp, rresp}, 0);
        chk({nm, "_rdata"}, rdata, 0);
        chk({nm, "_cmd"}, {cmd_write, cmd_addr, cmd_wstrb}, 0);
        chk({nm, "_cmd_wdata"}, cmd_wdata, 0);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int  lat;
        bit  bad_hold;
        bit  bad_stable;
        lat = 0; bad_hold = 1'b0; bad_stable = 1'b0;
        @(negedge clk);
        cmd_ready = 1'b0; rsp_valid = 1'b0;
        if (v.wr) begin
            awvalid = 1'b1; awid = v.id; awaddr = v.addr; awlen = v.len;
            wvalid = 1'b1; wdata = v.data; wstrb = v.strb; wlast = v.wlast;
        end else begin
            arvalid = 1'b1; arid = v.id; araddr = v.addr; arlen = v.len;
        end
        #1;
        chk({nm, "_accept"}, {awready, wready, arready}, v.wr ? 3'b110 : 3'b001);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        if (v.legal) begin
            chk({nm, "_cmd"}, {cmd_valid, cmd_write}, {1'b1, v.wr});
            chk({nm, "_cmd_addr"}, cmd_addr, v.addr);
            if (v.wr) begin
                chk({nm, "_cmd_wdata"}, cmd_wdata, v.data);
                chk({nm, "_cmd_wstrb"}, cmd_wstrb, v.strb);
            end
        end else begin
            chk({nm, "_no_cmd"}, cmd_valid, 0);
        end
        for (int k = 1; k <= 40; k++) begin
            if (bvalid || rvalid) begin
                lat = k;
                break;
            end
            if (v.legal && k <= v.stall + 1 && (!cmd_valid || cmd_addr !== v.addr))
                bad_hold = 1'b1;
            cmd_ready = (k > v.stall);
            rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
            if (v.legal && k <= v.stall) begin
                // early response while the command is still pending
                rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = JUNK;
            end else if (v.legal && v.delay >= 0 && k == v.stall + 2 + v.delay) begin
                rsp_valid = 1'b1; rsp_err = v.err; rsp_rdata = v.data;
            end
            @(negedge clk);
        end
        rsp_valid = 1'b0; rsp_err = 1'b0;
        chk({nm, "_latency"}, lat, v.lat);
        if (v.wr) begin
            chk({nm, "_bchan"}, {rvalid, bid, bresp}, {1'b0, v.id, v.resp});
        end else begin
            chk({nm, "_rchan"}, {bvalid, rid, rresp, rlast}, {1'b0, v.id, v.resp, 1'b1});
            chk({nm, "_rdata"}, rdata, v.rdata);
        end
        for (int j = 0; j < v.bstall; j++) begin
            // late response while the result is waiting to be taken
            bready = 1'b0; rready = 1'b0;
            rsp_valid = 1'b1; rsp_err = 1'b1; rsp_rdata = JUNK;
            @(negedge clk);
            if (v.wr ? (!bvalid || bresp !== v.resp || bid !== v.id)
                     : (!rvalid || rresp !== v.resp || rdata !== v.rdata || rid !== v.id))
                bad_stable = 1'b1;
        end
        rsp_valid = 1'b0; rsp_err = 1'b0;
        if (v.bstall > 0) chk({nm, "_resp_hold"}, bad_stable, 0);
        if (v.legal) chk({nm, "_cmd_hold"}, bad_hold, 0);
        bready = v.wr; rready = !v.wr;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        chk({nm, "_done"}, {bvalid, rvalid}, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          wr   id      addr           data                  strb   len  wl st dl er bs lg resp   rdata                lat
        vecs[0] = '{1'b1, 5'd3,  32'h0000_0100, 64'h1122334455667788, 8'hFF, 4'd0, 1, 0, 0, 0, 0, 1, 2'b00, 64'h0,                3};
        vecs[1] = '{1'b0, 5'd7,  32'h0000_0200, 64'hDEADBEEF,         8'h00, 4'd0, 1, 0, 5, 0, 0, 1, 2'b00, 64'hDEADBEEF,         8};
        vecs[2] = '{1'b1, 5'd1,  32'h0000_0300, 64'h0BAD,             8'hFF, 4'd1, 1, 0, 0, 0, 1, 0, 2'b10, 64'h0,                1};
        vecs[3] = '{1'b0, 5'd2,  32'h0000_0400, 64'h0,                8'h00, 4'd3, 1, 0, 0, 0, 0, 0, 2'b10, 64'h0,                1};
        vecs[4] = '{1'b1, 5'd4,  32'h0000_0500, 64'h55,               8'h01, 4'd0, 0, 0, 0, 0, 0, 0, 2'b10, 64'h0,                1};
        vecs[5] = '{1'b0, 5'd5,  32'h0000_0600, 64'hCAFEF00D12345678, 8'h00, 4'd0, 1, 0, 1, 1, 2, 1, 2'b10, 64'hCAFEF00D12345678, 4};
        vecs[6] = '{1'b1, 5'd6,  32'h0000_0700, 64'hA5A5A5A5A5A5A5A5, 8'h0F, 4'd0, 1, 3, 2, 1, 2, 1, 2'b10, 64'h0,                8};
        vecs[7] = '{1'b0, 5'h1F, 32'hFFFF_FFFC, 64'h0,                8'h00, 4'd0, 1, 0,-1, 0, 1, 1, 2'b11, 64'h0,               10};
        vecs[8] = '{1'b0, 5'd0,  32'h0000_0008, 64'h0123456789ABCDEF, 8'h00, 4'd0, 1, 0, 0, 0, 0, 1, 2'b00, 64'h0123456789ABCDEF, 3};
        vecs[9] = '{1'b1, 5'h10, 32'h0000_0010, 64'hFFFF0000FFFF0000, 8'hF0, 4'd0, 1, 1, 7, 0, 0, 1, 2'b00, 64'h0,               11};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Contended requests right after reset: write first, then alternate.
        begin : arb
            int grants;
            int cyc;
            bit dbl;
            bit exp_wr [4];
            grants = 0; cyc = 0; dbl = 1'b0;
            exp_wr[0] = 1'b1; exp_wr[1] = 1'b0; exp_wr[2] = 1'b1; exp_wr[3] = 1'b0;
            @(negedge clk);
            awvalid = 1'b1; awid = 5'd9;  awaddr = 32'hA0; awlen = '0;
            wvalid = 1'b1;  wdata = 64'h77; wstrb = 8'hFF; wlast = 1'b1;
            arvalid = 1'b1; arid = 5'd10; araddr = 32'hB0; arlen = '0;
            cmd_ready = 1'b1; rsp_valid = 1'b1; bready = 1'b1; rready = 1'b1;
            while (grants < 4 && cyc < 60) begin
                #1;
                if ((awready || wready) && arready) dbl = 1'b1;
                if (awready && wready && !arready) begin
                    chk($sformatf("arb_grant%0d_is_write", grants), 1, exp_wr[grants]);
                    grants++;
                end else if (arready && !awready && !wready) begin
                    chk($sformatf("arb_grant%0d_is_write", grants), 0, exp_wr[grants]);
                    grants++;
                end
                @(negedge clk);
                cyc++;
            end
            idle_inputs();
            bready = 1'b1; rready = 1'b1; cmd_ready = 1'b1; rsp_valid = 1'b1;
            chk("arb_grant_count", grants, 4);
            chk("arb_no_double_ready", dbl, 0);
            repeat (6) @(negedge clk);
            idle_inputs();
            @(negedge clk);
            chk("arb_drained", {bvalid, rvalid, cmd_valid}, 0);
        end

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset while waiting on the backend.
        @(negedge clk);
        awvalid = 1'b1; awid = 5'd11; awaddr = 32'hC0; awlen = '0;
        wvalid = 1'b1; wdata = 64'h1; wstrb = 8'h01; wlast = 1'b1;
        cmd_ready = 1'b1;
        #1;
        chk("rst_wait_accept", {awready, wready}, 2'b11);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_wait_in_wait", {cmd_valid, bvalid, rvalid}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_wait_cleared", {cmd_valid, bvalid, rvalid}, 0);
        rsp_valid = 1'b1; rsp_rdata = JUNK;
        @(negedge clk);
        rsp_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wait_late_rsp_dropped", {cmd_valid, bvalid, rvalid}, 0);

        // Reset while a write response is stalled on BREADY.
        awvalid = 1'b1; awid = 5'd12; awaddr = 32'hD0; awlen = '0;
        wvalid = 1'b1; wdata = 64'h2; wstrb = 8'h02; wlast = 1'b1;
        cmd_ready = 1'b1; bready = 1'b0;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b1; rsp_err = 1'b0;
        @(negedge clk);
        rsp_valid = 1'b0;
        chk("rst_resp_bvalid", {bvalid, bid}, {1'b1, 5'd12});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_cleared", {bvalid, rvalid, cmd_valid, bid, bresp}, 0);
        idle_inputs();

        run_txn(vecs[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
